// File: rtl/vga_timing_driver_pkg.sv
// Shared 640x480@60 Hz timing constants, sync bundle type and small helpers
// used by the VGA timing driver and its delay line.
package vga_timing_driver_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam int FRAME_WIDTH  = H_VISIBLE;
  localparam int FRAME_HEIGHT = V_VISIBLE;

  localparam int CNT_W   = 10;
  localparam int COORD_W = 12;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  typedef struct packed {
    logic hs;
    logic vs;
    logic active;
  } sync_t;

  // Blanked, no-sync state: both syncs idle high, video inactive.
  localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, active: 1'b0};

  function automatic logic in_window(input logic [COORD_W-1:0] cnt,
                                     input int lo, input int len);
    return (cnt >= COORD_W'(lo)) && (cnt < COORD_W'(lo + len));
  endfunction

  function automatic logic [7:0] dac_level(input logic bit_on);
    return bit_on ? 8'hFF : 8'h00;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register that aligns a bundle of control bits with a
// downstream data path; depth 0 degenerates to a plain wire.
module vga_delay_line #(
  parameter int               WIDTH       = 3,
  parameter int               DEPTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             CLOCK_25,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign dout = din;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage [DEPTH];

      // NOTE: every stage is reset, not just the last one, so a flush leaves no
      // stale sync pulse queued behind the reset value.
      always_ff @(posedge CLOCK_25) begin
        if (reset) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VALUE;
        end else begin
          stage[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_driver.sv
// 640x480@60 Hz scan master: presents 1-based pixel coordinates to the image
// generator and drives the VGA DAC with colour, sync and blank aligned to it.
module vga_timing_driver
  import vga_timing_driver_pkg::*;
#(
  parameter int unsigned COLOR_LATENCY = 1
) (
  input  logic               CLOCK_25,
  input  logic               reset,
  input  logic [2:0]         color,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               line_start,
  output logic               frame_start,
  output logic               VGA_CLK,
  output logic               VGA_HS,
  output logic               VGA_VS,
  output logic               VGA_BLANK_N,
  output logic               VGA_SYNC_N,
  output logic [7:0]         VGA_R,
  output logic [7:0]         VGA_G,
  output logic [7:0]         VGA_B
);

  logic [CNT_W-1:0]   h_count;
  logic [CNT_W-1:0]   v_count;
  logic [COORD_W-1:0] h_ext;
  logic [COORD_W-1:0] v_ext;
  sync_t              raw;
  sync_t              delayed;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLOCK_25) begin
    if (reset) begin
      h_count <= '0;
      v_count <= '0;
    end else if (h_count == H_LAST) begin
      h_count <= '0;
      v_count <= (v_count == V_LAST) ? '0 : v_count + 1'b1;
    end else begin
      h_count <= h_count + 1'b1;
    end
  end

  assign h_ext = COORD_W'(h_count);
  assign v_ext = COORD_W'(v_count);

  // NOTE: every field is given a default before the decode so no latch can form.
  always_comb begin
    raw        = SYNC_IDLE;
    raw.hs     = ~in_window(h_ext, H_VISIBLE + H_FRONT, H_SYNC);
    raw.vs     = ~in_window(v_ext, V_VISIBLE + V_FRONT, V_SYNC);
    raw.active = (h_ext < COORD_W'(FRAME_WIDTH)) && (v_ext < COORD_W'(FRAME_HEIGHT));
  end

  // Coordinates and strobes come straight from the counter registers, so the
  // generator sees them undelayed and glitch-free.
  assign x           = raw.active ? h_ext + 1'b1 : '0;
  assign y           = raw.active ? v_ext + 1'b1 : '0;
  assign line_start  = (h_count == '0) && !reset;
  assign frame_start = line_start && (v_count == '0);

  vga_delay_line #(
    .WIDTH       ($bits(sync_t)),
    .DEPTH       (int'(COLOR_LATENCY)),
    .RESET_VALUE (SYNC_IDLE)
  ) u_sync_delay (
    .CLOCK_25 (CLOCK_25),
    .reset    (reset),
    .din      (raw),
    .dout     (delayed)
  );

  // Final register where the delayed timing meets the generator's colour.
  always_ff @(posedge CLOCK_25) begin
    if (reset) begin
      VGA_HS      <= SYNC_IDLE.hs;
      VGA_VS      <= SYNC_IDLE.vs;
      VGA_BLANK_N <= SYNC_IDLE.active;
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
    end else begin
      VGA_HS      <= delayed.hs;
      VGA_VS      <= delayed.vs;
      VGA_BLANK_N <= delayed.active;
      VGA_R       <= dac_level(delayed.active & color[2]);
      VGA_G       <= dac_level(delayed.active & color[1]);
      VGA_B       <= dac_level(delayed.active & color[0]);
    end
  end

  assign VGA_CLK    = ~CLOCK_25;
  assign VGA_SYNC_N = 1'b0;

endmodule

// File: tb/tb_vga_timing_driver.sv
// Self-checking bench: three drivers (colour latency 0, 1, 3) run side by side
// against a cycle-index scan model and a latency-aware model colour generator.
module tb_vga_timing_driver;

  localparam int ND = 3;

  function automatic int lat_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 1 : 3);
  endfunction

  function automatic logic [7:0] lvl(input logic b);
    return b ? 8'hFF : 8'h00;
  endfunction

  logic       CLOCK_25 = 1'b0;
  logic       reset    = 1'b1;
  logic [2:0] color [ND];

  wire [11:0] x_o  [ND];
  wire [11:0] y_o  [ND];
  wire        ls_o [ND];
  wire        fs_o [ND];
  wire        clk_o[ND];
  wire        hs_o [ND];
  wire        vs_o [ND];
  wire        bn_o [ND];
  wire        sn_o [ND];
  wire [7:0]  r_o  [ND];
  wire [7:0]  g_o  [ND];
  wire [7:0]  b_o  [ND];

  always #20 CLOCK_25 = ~CLOCK_25;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    vga_timing_driver #(.COLOR_LATENCY(lat_of(g))) dut (
      .CLOCK_25    (CLOCK_25),
      .reset       (reset),
      .color       (color[g]),
      .x           (x_o[g]),
      .y           (y_o[g]),
      .line_start  (ls_o[g]),
      .frame_start (fs_o[g]),
      .VGA_CLK     (clk_o[g]),
      .VGA_HS      (hs_o[g]),
      .VGA_VS      (vs_o[g]),
      .VGA_BLANK_N (bn_o[g]),
      .VGA_SYNC_N  (sn_o[g]),
      .VGA_R       (r_o[g]),
      .VGA_G       (g_o[g]),
      .VGA_B       (b_o[g])
    );
  end

  int checks   = 0;
  int failures = 0;

  // Model state: edges seen, last edge that sampled reset high, scan index
  // and generator colour per cycle (ring deep enough for latency 3).
  int         edge_cnt = 0;
  int         last_r   = 0;
  int         mode     = 0;  // 0 random, 1 green at x==1, 2 white
  int         n_hist   [8];
  logic [2:0] col_hist [8];

  // Advance one clock; rst_next is the reset level for the new cycle.
  // Every cycle all pins of every instance are compared to the scan model.
  task automatic step(input logic rst_next);
    int n, h, v;
    logic [11:0] ex, ey;
    logic e_ls, e_fs;
    @(posedge CLOCK_25);
    edge_cnt++;
    if (reset) last_r = edge_cnt;
    #1;
    reset = rst_next;
    n = edge_cnt - last_r;
    h = n % 800;
    v = (n / 800) % 525;
    ex = (h < 640 && v < 480) ? 12'(h + 1) : 12'd0;
    ey = (h < 640 && v < 480) ? 12'(v + 1) : 12'd0;
    n_hist[edge_cnt % 8] = n;
    case (mode)
      0:       col_hist[edge_cnt % 8] = 3'($urandom);
      1:       col_hist[edge_cnt % 8] = (ex == 12'd1) ? 3'b010 : 3'b000;
      default: col_hist[edge_cnt % 8] = 3'b111;
    endcase
    for (int d = 0; d < ND; d++)
      color[d] = col_hist[(((edge_cnt - lat_of(d)) % 8) + 8) % 8];
    e_ls = (h == 0) && !reset;
    e_fs = e_ls && (v == 0);
    @(negedge CLOCK_25);
    for (int d = 0; d < ND; d++) begin
      int L, c, ph, pv;
      logic e_hs, e_vs, e_bn;
      logic [2:0] e_col;
      logic [54:0] expv, gotv;
      L = lat_of(d);
      if (edge_cnt - last_r <= L) begin
        e_hs = 1'b1; e_vs = 1'b1; e_bn = 1'b0; e_col = 3'b000;
      end else begin
        c  = edge_cnt - L - 1;
        ph = n_hist[c % 8] % 800;
        pv = (n_hist[c % 8] / 800) % 525;
        e_hs  = !(ph >= 656 && ph < 752);
        e_vs  = !(pv >= 490 && pv < 492);
        e_bn  = (ph < 640) && (pv < 480);
        e_col = e_bn ? col_hist[c % 8] : 3'b000;
      end
      expv = {ex, ey, e_ls, e_fs, 1'b1, e_hs, e_vs, e_bn, 1'b0,
              lvl(e_col[2]), lvl(e_col[1]), lvl(e_col[0])};
      gotv = {x_o[d], y_o[d], ls_o[d], fs_o[d], clk_o[d], hs_o[d], vs_o[d],
              bn_o[d], sn_o[d], r_o[d], g_o[d], b_o[d]};
      checks++;
      if (gotv !== expv) begin
        failures++;
        $display("FAIL pins lat=%0d edge=%0d got=%h expected=%h", L, edge_cnt, gotv, expv);
      end
    end
  endtask

  task automatic align_line();
    int k = 0;
    do begin
      step(1'b0);
      k++;
    end while (!ls_o[0] && k < 1000);
    checks++;
    if (ls_o[0] !== 1'b1) begin
      failures++;
      $display("FAIL align_line_start got=%b expected=1 within 1000 cycles", ls_o[0]);
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 5; k++) begin
      step(1'b1);
      for (int d = 0; d < ND; d++) begin
        checks++;
        if ({x_o[d], y_o[d], hs_o[d], vs_o[d], bn_o[d], ls_o[d], fs_o[d], r_o[d], g_o[d], b_o[d]}
            !== {12'd1, 12'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0}) begin
          failures++;
          $display("FAIL reset_state lat=%0d got x=%0d y=%0d hs=%b vs=%b bn=%b ls=%b fs=%b rgb=%h%h%h expected x=1 y=1 hs=1 vs=1 bn=0 ls=0 fs=0 rgb=0",
                   lat_of(d), x_o[d], y_o[d], hs_o[d], vs_o[d], bn_o[d], ls_o[d], fs_o[d], r_o[d], g_o[d], b_o[d]);
        end
      end
    end
    step(1'b0);
    for (int d = 0; d < ND; d++) begin
      checks++;
      if ({fs_o[d], ls_o[d], x_o[d], y_o[d]} !== {1'b1, 1'b1, 12'd1, 12'd1}) begin
        failures++;
        $display("FAIL first_pixel lat=%0d got fs=%b ls=%b x=%0d y=%0d expected fs=1 ls=1 x=1 y=1",
                 lat_of(d), fs_o[d], ls_o[d], x_o[d], y_o[d]);
      end
    end
  endtask

  task automatic test_free_run();
    int bad_x = 0;
    int k = 0;
    mode = 0;
    for (k = 1; k < 800; k++) begin
      step(1'b0);
      if (x_o[0] !== ((k < 640) ? 12'(k + 1) : 12'd0)) bad_x++;
    end
    checks++;
    if (bad_x != 0) begin
      failures++;
      $display("FAIL x_sequence got %0d wrong cycles expected 0", bad_x);
    end
    k = 0;
    do begin
      step(1'b0);
      k++;
    end while (!ls_o[0] && k < 1000);
    checks++;
    if (k != 1 || ls_o[0] !== 1'b1) begin
      failures++;
      $display("FAIL line_period got %0d extra cycles ls=%b expected line_start at cycle 800", k, ls_o[0]);
    end
    for (int i = 0; i < 3 * 800; i++) step(1'b0);
  endtask

  task automatic test_green_pulse();
    int g_cnt[ND], g_first[ND], rb_bad[ND];
    mode = 1;
    align_line();
    for (int d = 0; d < ND; d++) begin g_cnt[d] = 0; g_first[d] = -1; rb_bad[d] = 0; end
    for (int k = 1; k < 1600; k++) begin
      step(1'b0);
      for (int d = 0; d < ND; d++) begin
        if (g_o[d] == 8'hFF) begin
          if (g_first[d] < 0) g_first[d] = k;
          g_cnt[d]++;
        end
        if (r_o[d] != 8'h00 || b_o[d] != 8'h00) rb_bad[d]++;
      end
    end
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (g_cnt[d] != 2 || g_first[d] != lat_of(d) + 1 || rb_bad[d] != 0) begin
        failures++;
        $display("FAIL green_pulse lat=%0d got count=%0d offset=%0d rb_bad=%0d expected count=2 offset=%0d rb_bad=0",
                 lat_of(d), g_cnt[d], g_first[d], rb_bad[d], lat_of(d) + 1);
      end
    end
  endtask

  task automatic test_hsync();
    int fall[ND], rise[ND];
    logic prev[ND];
    align_line();
    for (int d = 0; d < ND; d++) begin fall[d] = -1; rise[d] = -1; prev[d] = hs_o[d]; end
    for (int k = 1; k < 900; k++) begin
      step(1'b0);
      for (int d = 0; d < ND; d++) begin
        if (prev[d] && !hs_o[d] && fall[d] < 0) fall[d] = k;
        if (!prev[d] && hs_o[d] && fall[d] >= 0 && rise[d] < 0) rise[d] = k;
        prev[d] = hs_o[d];
      end
    end
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (fall[d] != 657 + lat_of(d) || rise[d] - fall[d] != 96) begin
        failures++;
        $display("FAIL hsync lat=%0d got fall=%0d width=%0d expected fall=%0d width=96",
                 lat_of(d), fall[d], rise[d] - fall[d], 657 + lat_of(d));
      end
    end
  endtask

  task automatic test_white();
    int bn_cnt[ND], bad[ND];
    mode = 2;
    align_line();
    for (int d = 0; d < ND; d++) begin bn_cnt[d] = 0; bad[d] = 0; end
    for (int k = 0; k < 800; k++) begin
      if (k != 0) step(1'b0);
      for (int d = 0; d < ND; d++) begin
        if (bn_o[d]) bn_cnt[d]++;
        if ({r_o[d], g_o[d], b_o[d]} !== (bn_o[d] ? 24'hFFFFFF : 24'h000000)) bad[d]++;
      end
    end
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (bn_cnt[d] != 640 || bad[d] != 0) begin
        failures++;
        $display("FAIL white_blank lat=%0d got blank_n_high=%0d rgb_bad=%0d expected 640 and 0",
                 lat_of(d), bn_cnt[d], bad[d]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int k = 0;
    mode = 0;
    align_line();
    for (int i = 1; i < 700; i++) step(1'b0);
    step(1'b1);
    step(1'b0);
    for (int d = 0; d < ND; d++) begin
      checks++;
      if ({x_o[d], y_o[d], ls_o[d], fs_o[d], hs_o[d], vs_o[d], bn_o[d]}
          !== {12'd1, 12'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL reset_mid lat=%0d got x=%0d y=%0d ls=%b fs=%b hs=%b vs=%b bn=%b expected 1 1 1 1 1 1 0",
                 lat_of(d), x_o[d], y_o[d], ls_o[d], fs_o[d], hs_o[d], vs_o[d], bn_o[d]);
      end
    end
    do begin
      step(1'b0);
      k++;
    end while (!ls_o[0] && k < 1000);
    checks++;
    if (k != 800 || y_o[0] !== 12'd2 || fs_o[0] !== 1'b0) begin
      failures++;
      $display("FAIL restart_period got period=%0d y=%0d fs=%b expected 800 2 0", k, y_o[0], fs_o[0]);
    end
  endtask

  task automatic test_random_soak();
    mode = 0;
    for (int i = 0; i < 6 * 800; i++) step(1'b0);
  endtask

  initial begin
    for (int d = 0; d < ND; d++) color[d] = 3'b000;
    for (int i = 0; i < 8; i++) begin n_hist[i] = 0; col_hist[i] = 3'b000; end
    test_reset();
    test_free_run();
    test_green_pulse();
    test_hsync();
    test_white();
    test_reset_mid();
    test_hsync();
    test_random_soak();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #4000000;
    $display("FAIL timeout got no summary within 100000 cycles expected completion");
    $fatal(1, "simulation timeout");
  end

endmodule

// File: doc/vga_timing_driver.md
Name: vga_timing_driver

Overview:
- Master end of the pixel-coordinate interface consumed by img_generator: scans a 640x480@60 Hz frame, presents 1-based x/y for each pixel and samples the returned 3-bit color.
- Converts color to 8-bit VGA DAC channels and generates sync/blank, delay-matched to the color path.
- Sits between img_generator and the board VGA pins.
- Also exports frame/line strobes for game-logic timing.

Parameters:
- COLOR_LATENCY, 1, clock cycles from x/y presentation to valid color on the color input (range 0..3).

Ports:
- CLOCK_25  in  1  25 MHz pixel clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- color  in  3  pixel color from generator; [2]=R, [1]=G, [0]=B.
- x  out  12  presented column, 1..640 in active video, 0 in blanking.
- y  out  12  presented row, 1..480 in active video, 0 in blanking.
- line_start  out  1  one-cycle pulse while h_count=0.
- frame_start  out  1  one-cycle pulse while h_count=0 and v_count=0.
- VGA_CLK  out  1  pixel clock forwarded to the DAC (inverted CLOCK_25).
- VGA_HS  out  1  horizontal sync, active low.
- VGA_VS  out  1  vertical sync, active low.
- VGA_BLANK_N  out  1  low outside active video.
- VGA_SYNC_N  out  1  constant 0.
- VGA_R / VGA_G / VGA_B  out  8 each  8'hFF when the corresponding color bit is 1, else 8'h00; forced to 0 when blanked.

Behaviour:
- Clock and reset: one clock, CLOCK_25. Reset is synchronous and active-high.
- Counters:
  - h_count 0..799: wraps to 0 after 799.
  - v_count 0..524: increments when h_count wraps; wraps to 0 after 524.
  - Reset holds both at 0.
- Horizontal timing: visible 0..639, front porch 640..655, sync 656..751, back porch 752..799.
- Vertical timing: visible 0..479, front porch 480..489, sync 490..491, back porch 492..524.
- Active video: h_count<640 and v_count<480.
  - During active video: x=h_count+1, y=v_count+1.
  - Outside active video: x=0, y=0, both at once.
  - x/y are decoded from the counter registers only, so they are glitch-free.
- Strobes:
  - line_start and frame_start are undelayed and aligned with x/y.
  - During reset, x=1, y=1, line_start=0, frame_start=0.
  - The first cycle after reset release presents pixel (1,1) with frame_start=1 and line_start=1.
- Pipeline alignment:
  - hs_raw, vs_raw and active_raw are computed from the counters.
  - They pass through a COLOR_LATENCY-stage delay line, then meet color in a final output register.
  - Pixel presented at cycle t therefore appears on the VGA pins at t+COLOR_LATENCY+1. The same latency applies to HS, VS and BLANK_N.
- Reset outputs: all delay stages and output registers clear to:
  - VGA_HS=1, VGA_VS=1;
  - VGA_BLANK_N=0;
  - RGB=0.
  This is the blanked, no-sync state.
- Blanking: RGB are 0 whenever delayed active is 0, regardless of color.
- Reset mid-frame: counters return to 0 on the next edge and the pipeline is flushed. After release, a clean frame starts at (1,1). No partial sync pulse may stretch beyond reset assertion.
- Width rules:
  - x/y zero-extended to 12 bits.
  - Comparisons use unsigned 12-bit arithmetic (10-bit counters zero-extended).
- Invariants:
  - Line period 800 cycles; frame period 420000 cycles.
  - HS low for exactly 96 cycles/line.
  - VS low for exactly 1600 cycles/frame.

Decomposition:
- Timing constants go into global_symbols.vh as `defines, shared with img_generator: H_VISIBLE, H_FRONT, H_SYNC, H_BACK, H_TOTAL and the V_ equivalents.
- FRAME_WIDTH/FRAME_HEIGHT stay consistent with H_VISIBLE/V_VISIBLE.
- One sub-module: vga_delay_line, parameterised width and depth (depth 0 = wire), used for the 3-bit {hs,vs,active} alignment.

Test Plan:
- Reset 5 cycles, release:
  - during reset x=1, y=1, HS=VS=1, BLANK_N=0, RGB=0;
  - first cycle after release frame_start=1, line_start=1, x=1, y=1.
- Free-run 2 frames:
  - line_start period exactly 800 cycles, frame_start period exactly 420000;
  - x sequence 1..640 then 160 zeros;
  - y=481..525 region reads 0.
- COLOR_LATENCY=1, model generator returning color=3'b010 only when x==1:
  - VGA_G=8'hFF for exactly one cycle per visible line, 2 cycles after x=1 was presented;
  - R=B=0.
- Measure HS:
  - falling edge 656+COLOR_LATENCY+1 cycles after line_start, low for 96 cycles;
  - VS low for 1600 cycles starting line 490.
- Drive color=3'b111 constantly: RGB=8'h00 whenever BLANK_N=0, 8'hFF otherwise; BLANK_N high 640 cycles per visible line.
- Assert reset at h=700, v=300 for 1 cycle: next cycle x=1, y=1, HS=VS=1 after pipeline flush; timing repeats from frame start.
- Repeat with COLOR_LATENCY=0 and 3 to confirm alignment.
